// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite blitter: FSM state encoding,
// pixel type, framebuffer geometry and the on-screen test.
package sprite_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SCAN   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    typedef logic [15:0] rgb565_t;

    localparam rgb565_t TRANSPARENT_DEF = 16'hFFFF;
    localparam int      FB_W_DEF        = 320;
    localparam int      FB_H_DEF        = 240;

    // Screen coordinates are 11 bits so pos + offset never wraps.
    function automatic logic on_screen(input logic [10:0] sx, input logic [10:0] sy,
                                       input logic [10:0] w_lim, input logic [10:0] h_lim);
        return (sx < w_lim) && (sy < h_lim);
    endfunction

endpackage

// File: rtl/sprite_blit_ctrl_addr_gen.sv
// Incremental row/col, ROM pixel index and framebuffer line base counters
// for one sprite blit; no multiply on the per-pixel path.
module sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter int FB_W  = FB_W_DEF,
    parameter int FB_AW = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init,
    input  logic             advance,
    input  logic             flip_h,
    input  logic [9:0]       pos_x,
    input  logic [9:0]       pos_y,
    input  logic [5:0]       rom_width,
    input  logic [5:0]       rom_height,
    output logic [16:0]      rom_pixel,
    output logic [10:0]      sx,
    output logic [10:0]      sy,
    output logic [FB_AW-1:0] line_base,
    output logic             last
);

    logic [5:0]       w_r;
    logic [5:0]       h_r;
    logic [5:0]       col_r;
    logic [5:0]       row_r;
    logic [16:0]      pix_r;
    logic [FB_AW-1:0] lb_r;
    logic             row_end_s;

    assign row_end_s = (col_r == (w_r - 6'd1));
    assign last      = row_end_s && (row_r == (h_r - 6'd1));
    assign sx        = {1'b0, pos_x} + {5'd0, col_r};
    assign sy        = {1'b0, pos_y} + {5'd0, row_r};
    assign rom_pixel = pix_r;
    assign line_base = lb_r;

    // Counter state: load on SETUP, step on every advance.
    // line_base wraps modulo 2**FB_AW; only used when sy is on screen, where it is exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_r   <= 6'd0;
            h_r   <= 6'd0;
            col_r <= 6'd0;
            row_r <= 6'd0;
            pix_r <= 17'd0;
            lb_r  <= {FB_AW{1'b0}};
        end else if (init) begin
            w_r <= rom_width;
            h_r <= rom_height;
            if ((rom_width != 6'd0) && (rom_height != 6'd0)) begin
                col_r <= 6'd0;
                row_r <= 6'd0;
                pix_r <= flip_h ? (17'(rom_width) - 17'd1) : 17'd0;
                lb_r  <= FB_AW'(pos_y) * FB_AW'(FB_W);
            end else begin
                pix_r <= pix_r;
            end
        end else if (advance) begin
            if (row_end_s) begin
                col_r <= 6'd0;
                row_r <= row_r + 6'd1;
                lb_r  <= lb_r + FB_AW'(FB_W);
                // Flipped: jump from this row's left edge to the next row's right edge.
                pix_r <= flip_h ? (pix_r + 17'({w_r, 1'b0}) - 17'd1) : (pix_r + 17'd1);
            end else begin
                col_r <= col_r + 6'd1;
                pix_r <= flip_h ? (pix_r - 17'd1) : (pix_r + 17'd1);
            end
        end else begin
            pix_r <= pix_r;
        end
    end

endmodule

// File: rtl/sprite_blit_ctrl.sv
// Blit sequencer: walks a sprite ROM, skips key-colored and off-screen pixels,
// and issues one valid/ready framebuffer write per remaining pixel.
module sprite_blit_ctrl
    import sprite_pkg::*;
#(
    parameter int      FB_W        = FB_W_DEF,
    parameter int      FB_H        = FB_H_DEF,
    parameter int      FB_AW       = 17,
    parameter rgb565_t TRANSPARENT = TRANSPARENT_DEF,
    parameter int      NFRAMES     = 2,
    localparam int     SEL_W       = (NFRAMES > 1) ? $clog2(NFRAMES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [9:0]       pos_x,
    input  logic [9:0]       pos_y,
    input  logic [SEL_W-1:0] frame_sel,
    input  logic             flip_h,
    output logic [SEL_W-1:0] rom_sel,
    output logic [16:0]      rom_pixel,
    input  logic [15:0]      rom_color,
    input  logic [5:0]       rom_width,
    input  logic [5:0]       rom_height,
    output logic [FB_AW-1:0] fb_addr,
    output logic [15:0]      fb_data,
    output logic             fb_valid,
    input  logic             fb_ready,
    output logic             busy,
    output logic             done
);

    state_t           state_r;
    state_t           state_s;
    logic [9:0]       pos_x_r;
    logic [9:0]       pos_y_r;
    logic             flip_r;
    logic [SEL_W-1:0] rom_sel_r;
    logic [FB_AW-1:0] fb_addr_r;
    rgb565_t          fb_data_r;
    logic             fb_valid_r;
    logic             busy_r;
    logic             done_r;

    logic             busy_s;
    logic             done_s;
    logic             valid_s;
    logic             write_pix_s;
    logic             advance_s;
    logic             init_s;
    logic             last_s;
    logic [10:0]      sx_s;
    logic [10:0]      sy_s;
    logic [FB_AW-1:0] line_base_s;

    assign write_pix_s = (rom_color != TRANSPARENT) && on_screen(sx_s, sy_s, 11'(FB_W), 11'(FB_H));
    assign init_s      = (state_r == ST_SETUP);
    assign advance_s   = ((state_r == ST_SCAN) && !write_pix_s) || ((state_r == ST_WRITE) && fb_ready);

    sprite_addr_gen #(
        .FB_W  (FB_W),
        .FB_AW (FB_AW)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .init       (init_s),
        .advance    (advance_s),
        .flip_h     (flip_r),
        .pos_x      (pos_x_r),
        .pos_y      (pos_y_r),
        .rom_width  (rom_width),
        .rom_height (rom_height),
        .rom_pixel  (rom_pixel),
        .sx         (sx_s),
        .sy         (sy_s),
        .line_base  (line_base_s),
        .last       (last_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:   state_s = start ? ST_SETUP : ST_IDLE;
            ST_SETUP:  state_s = ((rom_width == 6'd0) || (rom_height == 6'd0)) ? ST_FINISH : ST_SCAN;
            ST_SCAN: begin
                if (write_pix_s) begin
                    state_s = ST_WRITE;
                end else begin
                    state_s = last_s ? ST_FINISH : ST_SCAN;
                end
            end
            ST_WRITE: begin
                if (fb_ready) begin
                    state_s = last_s ? ST_FINISH : ST_SCAN;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_FINISH: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the status flags can be registered.
    always_comb begin
        busy_s  = 1'b0;
        done_s  = 1'b0;
        valid_s = 1'b0;
        case (state_s)
            ST_SETUP, ST_SCAN: busy_s = 1'b1;
            ST_WRITE: begin
                busy_s  = 1'b1;
                valid_s = 1'b1;
            end
            ST_FINISH: done_s = 1'b1;
            default:   busy_s = 1'b0;
        endcase
    end

    // Registered outputs and the request latched at start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x_r    <= 10'd0;
            pos_y_r    <= 10'd0;
            flip_r     <= 1'b0;
            rom_sel_r  <= {SEL_W{1'b0}};
            fb_addr_r  <= {FB_AW{1'b0}};
            fb_data_r  <= 16'd0;
            fb_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            busy_r     <= busy_s;
            done_r     <= done_s;
            fb_valid_r <= valid_s;
            if ((state_r == ST_IDLE) && start) begin
                pos_x_r   <= pos_x;
                pos_y_r   <= pos_y;
                flip_r    <= flip_h;
                rom_sel_r <= frame_sel;
            end
            if ((state_r == ST_SCAN) && write_pix_s) begin
                fb_addr_r <= line_base_s + FB_AW'(sx_s);
                fb_data_r <= rom_color;
            end
        end
    end

    assign rom_sel  = rom_sel_r;
    assign fb_addr  = fb_addr_r;
    assign fb_data  = fb_data_r;
    assign fb_valid = fb_valid_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_sprite_blit_ctrl.sv
// Self-checking bench for sprite_blit_ctrl: directed scenarios plus randomized
// blits compared against a per-pixel reference model of the blit.
module tb_sprite_blit_ctrl;

    localparam int FB_W  = 320;
    localparam int FB_H  = 240;
    localparam int FB_AW = 17;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [9:0]        pos_x = 10'd0;
    logic [9:0]        pos_y = 10'd0;
    logic              frame_sel = 1'b0;
    logic              flip_h = 1'b0;
    logic              rom_sel;
    logic [16:0]       rom_pixel;
    logic [15:0]       rom_color;
    logic [5:0]        rom_width;
    logic [5:0]        rom_height;
    logic [FB_AW-1:0]  fb_addr;
    logic [15:0]       fb_data;
    logic              fb_valid;
    logic              fb_ready = 1'b1;
    logic              busy;
    logic              done;

    logic [15:0] rom_mem [0:1][0:4095];
    int          rom_w [2];
    int          rom_h [2];
    int          total = 0;
    int          bad = 0;
    int          pix_seen [$];

    always #5 clk = ~clk;

    always_comb begin
        rom_color  = rom_mem[rom_sel][rom_pixel[11:0]];
        rom_width  = 6'(rom_w[rom_sel]);
        rom_height = 6'(rom_h[rom_sel]);
    end

    sprite_blit_ctrl #(
        .FB_W        (FB_W),
        .FB_H        (FB_H),
        .FB_AW       (FB_AW),
        .TRANSPARENT (16'hFFFF),
        .NFRAMES     (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .frame_sel  (frame_sel),
        .flip_h     (flip_h),
        .rom_sel    (rom_sel),
        .rom_pixel  (rom_pixel),
        .rom_color  (rom_color),
        .rom_width  (rom_width),
        .rom_height (rom_height),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .fb_valid   (fb_valid),
        .fb_ready   (fb_ready),
        .busy       (busy),
        .done       (done)
    );

    task automatic fill_rom(input int f, input int w, input int h, input int tpct);
        for (int i = 0; i < w * h; i++) begin
            rom_mem[f][i] = ($urandom_range(0, 99) < tpct) ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFE));
        end
        rom_w[f] = w;
        rom_h[f] = h;
    endtask

    task automatic set_rom4(input int f, input int w, input int h,
                            input logic [15:0] c0, input logic [15:0] c1,
                            input logic [15:0] c2, input logic [15:0] c3);
        rom_mem[f][0] = c0;
        rom_mem[f][1] = c1;
        rom_mem[f][2] = c2;
        rom_mem[f][3] = c3;
        rom_w[f] = w;
        rom_h[f] = h;
    endtask

    // One complete blit: model the expected writes and latency, drive fb_ready, check everything.
    task automatic run_blit(input int px, input int py, input int f, input bit fl,
                            input int stall_first, input bit rand_ready, input bit poke, input string tag);
        int          ea [$];
        int          ed [$];
        bit          busy_tr [$];
        int          w = rom_w[f];
        int          h = rom_h[f];
        int          npix = w * h;
        int          nexp, nwr = 0, nstall = 0, stall_cnt = 0, ndone = 0, k_done = -1;
        int          exp_total, busy_bad = 0;
        bit          held = 1'b0;
        bit          poke_ok;
        logic [16:0] h_addr;
        logic [15:0] h_data;

        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                int          x = px + c;
                int          y = py + r;
                logic [15:0] col = rom_mem[f][r * w + (fl ? (w - 1 - c) : c)];
                if (col != 16'hFFFF && x < FB_W && y < FB_H) begin
                    ea.push_back(y * FB_W + x);
                    ed.push_back(int'(col));
                end
            end
        end
        nexp    = ea.size();
        poke_ok = poke && ((1 + npix + nexp) > 3);
        pix_seen.delete();

        @(negedge clk);
        pos_x     = 10'(px);
        pos_y     = 10'(py);
        frame_sel = 1'(f);
        flip_h    = fl;
        start     = 1'b1;
        fb_ready  = 1'b1;

        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (poke_ok && k == 2) start = 1'b1;
            if (poke_ok && k == 3) start = 1'b0;
            busy_tr.push_back(busy);
            if (done) begin
                ndone++;
                if (k_done < 0) k_done = k;
            end
            if (k >= 1 && busy && (pix_seen.size() == 0 || pix_seen[$] != int'(rom_pixel)))
                pix_seen.push_back(int'(rom_pixel));
            if (held) begin
                total++;
                if (fb_valid !== 1'b1 || fb_addr !== h_addr || fb_data !== h_data) begin
                    bad++;
                    $display("FAIL %s hold: valid=%0b addr=%0d data=%h, need valid=1 addr=%0d data=%h",
                             tag, fb_valid, fb_addr, fb_data, h_addr, h_data);
                end
            end
            if (fb_valid && nwr == 0 && stall_cnt < stall_first) begin
                fb_ready = 1'b0;
                stall_cnt++;
            end else begin
                fb_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            held = 1'b0;
            if (fb_valid && fb_ready) begin
                total++;
                if (ea.size() == 0) begin
                    bad++;
                    $display("FAIL %s extra_write: addr=%0d data=%h, need no write", tag, fb_addr, fb_data);
                end else begin
                    int a = ea.pop_front();
                    int d = ed.pop_front();
                    if (int'(fb_addr) != a || int'(fb_data) != d) begin
                        bad++;
                        $display("FAIL %s write%0d: addr=%0d data=%h, need addr=%0d data=%h",
                                 tag, nwr, fb_addr, fb_data, a, d[15:0]);
                    end
                end
                nwr++;
            end else if (fb_valid) begin
                nstall++;
                held   = 1'b1;
                h_addr = fb_addr;
                h_data = fb_data;
            end
            if (k_done >= 0 && k >= k_done + 3) break;
        end
        start    = 1'b0;
        fb_ready = 1'b1;

        exp_total = 1 + npix + nexp + nstall;
        total++;
        if (ndone != 1) begin
            bad++;
            $display("FAIL %s done_count: got %0d, need 1", tag, ndone);
        end
        total++;
        if (k_done != exp_total) begin
            bad++;
            $display("FAIL %s done_cycle: got %0d, need %0d", tag, k_done, exp_total);
        end
        total++;
        if (ea.size() != 0) begin
            bad++;
            $display("FAIL %s missing_writes: got %0d writes, need %0d", tag, nwr, nexp);
        end
        foreach (busy_tr[i]) begin
            if (busy_tr[i] != (i < exp_total)) busy_bad++;
        end
        total++;
        if (busy_bad != 0) begin
            bad++;
            $display("FAIL %s busy_trace: got %0d wrong cycles, need 0", tag, busy_bad);
        end
        total++;
        if (fb_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s valid_after: got %0b, need 0", tag, fb_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({rom_sel, rom_pixel, fb_addr, fb_data, fb_valid, busy, done} !== '0) begin
            bad++;
            $display("FAIL reset_hold: sel=%0d pix=%0d addr=%0d data=%h v=%0b b=%0b d=%0b, need all 0",
                     rom_sel, rom_pixel, fb_addr, fb_data, fb_valid, busy, done);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({fb_valid, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL reset_release: v=%0b b=%0b d=%0b, need 000", fb_valid, busy, done);
        end
    endtask

    task automatic test_opaque_2x2();
        set_rom4(0, 2, 2, 16'd1, 16'd2, 16'd3, 16'd4);
        run_blit(10, 5, 0, 1'b0, 0, 1'b0, 1'b0, "opaque2x2");
    endtask

    task automatic test_transparent_skip();
        set_rom4(1, 3, 1, 16'hFFFF, 16'h1234, 16'hFFFF, 16'h0000);
        run_blit(0, 0, 1, 1'b0, 0, 1'b0, 1'b0, "transp3x1");
    endtask

    task automatic test_clip_corner();
        set_rom4(0, 2, 2, 16'h0005, 16'h0006, 16'h0007, 16'h0008);
        run_blit(319, 239, 0, 1'b0, 0, 1'b0, 1'b0, "clip_corner");
    endtask

    task automatic test_flip();
        int exp_seq [4] = '{1, 0, 3, 2};
        int mism = 0;
        set_rom4(1, 2, 2, 16'd1, 16'd2, 16'd3, 16'd4);
        run_blit(0, 0, 1, 1'b1, 0, 1'b0, 1'b0, "flip2x2");
        if (pix_seen.size() != 4) mism++;
        else foreach (exp_seq[i]) if (pix_seen[i] != exp_seq[i]) mism++;
        total++;
        if (mism != 0) begin
            bad++;
            $display("FAIL flip_rom_pixel: got %p, need %p", pix_seen, exp_seq);
        end
    endtask

    task automatic test_stall_ignore_zero();
        fill_rom(0, 2, 2, 0);
        run_blit(100, 50, 0, 1'b0, 5, 1'b0, 1'b1, "stall_poke");
        rom_w[0] = 0;
        run_blit(20, 20, 0, 1'b0, 0, 1'b0, 1'b0, "zero_width");
    endtask

    task automatic test_reset_mid_write();
        int got_done = 0;
        set_rom4(0, 2, 2, 16'd1, 16'd2, 16'd3, 16'd4);
        @(negedge clk);
        pos_x = 10'd10; pos_y = 10'd5; frame_sel = 1'b0; flip_h = 1'b0;
        start = 1'b1; fb_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !fb_valid; i++) @(negedge clk);
        total++;
        if (fb_valid !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_wait: valid=%0b, need 1 within 20 cycles", fb_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({fb_valid, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL rst_mid_drop: v=%0b b=%0b d=%0b, need 000", fb_valid, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        fb_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done || busy) got_done++;
        end
        total++;
        if (got_done != 0) begin
            bad++;
            $display("FAIL rst_mid_quiet: got %0d active cycles, need 0", got_done);
        end
        run_blit(10, 5, 0, 1'b0, 0, 1'b0, 1'b0, "after_rst");
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            int f = $urandom_range(0, 1);
            fill_rom(f, $urandom_range(0, 7), $urandom_range(0, 7), 30);
            run_blit($urandom_range(0, 330), $urandom_range(0, 250), f, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3), 1'b1, 1'($urandom_range(0, 1)), $sformatf("rand%0d", it));
        end
    endtask

    initial begin
        test_reset();
        test_opaque_2x2();
        test_transparent_skip();
        test_clip_corner();
        test_flip();
        test_stall_ignore_zero();
        test_reset_mid_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_blit_ctrl.md
Name: sprite_blit_ctrl

Overview:
- Sequences one blit of a sprite ROM into the framebuffer.
- Walks the ROM pixel index row-major over the ROM-reported width/height and reads the RGB565 color back combinationally.
- Skips the transparent key color and clips off-screen pixels; each remaining pixel becomes one framebuffer write over a valid/ready handshake.
- Sits between the game/overworld sequencer (issues start, position, frame, flip) and the framebuffer write port; selects which animation-frame ROM is active for the duration of the blit.

Parameters:
- FB_W, 320, framebuffer width in pixels (also the address stride per line).
- FB_H, 240, framebuffer height in pixels.
- FB_AW, 17, framebuffer address width; must satisfy FB_W*FB_H <= 2**FB_AW.
- TRANSPARENT, 16'hFFFF, key color; pixels of this value are never written.
- NFRAMES, 2, number of animation-frame ROMs selectable.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a blit; sampled only in IDLE.
- pos_x  in  10  sprite left column on screen, unsigned.
- pos_y  in  10  sprite top row on screen, unsigned.
- frame_sel  in  $clog2(NFRAMES)  animation frame to draw.
- flip_h  in  1  1 = horizontally mirrored draw.
- rom_sel  out  $clog2(NFRAMES)  mux select to the frame ROMs; held for the whole blit.
- rom_pixel  out  17  registered ROM pixel index.
- rom_color  in  16  RGB565 color of rom_pixel, combinational from the ROM.
- rom_width  in  6  sprite width from the selected ROM.
- rom_height  in  6  sprite height from the selected ROM.
- fb_addr  out  FB_AW  framebuffer write address.
- fb_data  out  16  framebuffer write data.
- fb_valid  out  1  write request.
- fb_ready  in  1  framebuffer accepts the write this cycle.
- busy  out  1  blit in progress.
- done  out  1  one-cycle pulse at end of blit.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0: rom_sel, rom_pixel, fb_addr, fb_data, fb_valid, busy, done. Reset mid-blit abandons the blit immediately, drops fb_valid and produces no done.
- States: IDLE, SETUP, SCAN, WRITE, FINISH.
- IDLE:
  - start=1 latches pos_x, pos_y, flip_h, frame_sel (the latter to rom_sel); go to SETUP.
  - start is ignored in every other state (no queueing).
- SETUP (1 cycle, busy=1):
  - Latch w=rom_width, h=rom_height (the ROM now sees the new rom_sel).
  - If w==0 or h==0, go to FINISH.
  - Otherwise clear row and col, and set rom_pixel = flip_h ? w-1 : 0.
  - Set line_base = pos_y*FB_W; computed with an iterative add or a single multiply, implementer's choice, but ready by the end of SETUP.
  - Go to SCAN.
- Screen coordinates: sx = pos_x+col and sy = pos_y+row, both 11-bit. A pixel is clipped if sx >= FB_W or sy >= FB_H.
- SCAN (busy=1): evaluates the current pixel in a single cycle.
  - If rom_color==TRANSPARENT or the pixel is clipped: advance.
  - Otherwise: register fb_addr = line_base+sx and fb_data = rom_color, set fb_valid=1, go to WRITE.
- WRITE:
  - fb_valid, fb_addr and fb_data are held stable until fb_ready=1 is sampled.
  - On that edge drop fb_valid and advance, returning to SCAN or going to FINISH.
  - fb_valid never deasserts without fb_ready.
- Advance:
  - Mid-row: col+1, and rom_pixel +1 (unflipped) or -1 (flipped).
  - At col==w-1:
    - col=0, row+1, line_base += FB_W.
    - rom_pixel +1 (unflipped) or rom_pixel + 2w-1 (flipped), so the next row starts at its right edge.
  - At col==w-1 and row==h-1: go to FINISH.
- No multiplier on the per-pixel path; all index math is incremental.
- FINISH: done=1 and busy=0 for one cycle, then IDLE. rom_sel keeps its value until the next accepted start.
- Throughput: 1 cycle per skipped pixel; 2 cycles per written pixel with fb_ready held high.
- Latency: start accepted at edge T gives first SCAN at T+2. An all-transparent w*h sprite gives done at T+2+w*h.

Decomposition:
- Shared package sprite_pkg: the state enum, the RGB565 typedef, TRANSPARENT, FB_W and FB_H defaults.
- Optional sub-module sprite_addr_gen: the row/col/rom_pixel/line_base counters with an advance input and a last output. The FSM stays in sprite_blit_ctrl.

Test Plan:
- 2x2 all-opaque sprite (colors 1,2,3,4), pos (10,5), fb_ready=1 -> writes (1610,1),(1611,2),(1930,3),(1931,4) in order; done at T+2+8.
- 3x1 sprite {FFFF,0x1234,FFFF} at (0,0) -> exactly one write (1,0x1234); done at T+2+4.
- 2x2 sprite at (319,239) -> only (76799,color0) written; the other three pixels clipped; done still pulses once.
- flip_h=1, 2x2 {1,2,3,4} at (0,0) -> rom_pixel sequence 1,0,3,2; writes (0,2),(1,1),(320,4),(321,3).
- fb_ready low for 5 cycles on the first write -> fb_valid, fb_addr and fb_data stable all 5 cycles; start pulsed during busy is ignored; rom_width=0 -> no writes, done at T+2.
- rst_n asserted during WRITE -> fb_valid=0 and busy=0 immediately, no done; a subsequent start blits normally.
